sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Two-master to one-slave arbiter for the sram-like bus.
- Merges the instruction-fetch port (ifetch) and the data port (mem stage) onto a single sram-like port toward the cache/AXI bridge.
- Exactly one transaction outstanding at a time; data_ok/rdata are routed back to the owning master.
- Data port has priority; a starvation counter guarantees forward progress of instruction fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win (1..15).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active high (`RstEnable`)
inst_req  input  1  inst master request
inst_wr  input  1  inst write (normally 0)
inst_size  input  2  inst access size
inst_addr  input  32  inst physical address
inst_wdata  input  32  inst write data
inst_uncached  input  1  inst uncached attribute
inst_rdata  output  32  read data to inst master
inst_addr_ok  output  1  address accepted for inst
inst_data_ok  output  1  data done for inst
data_req  input  1  data master request
data_wr  input  1  data write
data_size  input  2  data access size
data_addr  input  32  data physical address
data_wdata  input  32  data write data
data_uncached  input  1  data uncached attribute
data_rdata  output  32  read data to data master
data_addr_ok  output  1  address accepted for data
data_data_ok  output  1  data done for data
mem_req  output  1  slave request
mem_wr  output  1  slave write
mem_size  output  2  slave size
mem_addr  output  32  slave address
mem_wdata  output  32  slave write data
mem_uncached  output  1  slave uncached attribute
mem_rdata  input  32  slave read data
mem_addr_ok  input  1  slave address accepted
mem_data_ok  input  1  slave data done

Behaviour:
- States: IDLE, LOCK, WAIT. Registers: state, sel (0 = inst, 1 = data), owner, starve_cnt (4 bits).
- Reset (synchronous): state = IDLE, sel = 0, owner = 0, starve_cnt = 0. While rst = 1, mem_req, all *_addr_ok and all *_data_ok are 0.
- Grant in IDLE (combinational):
  - Only data_req: grant data.
  - Only inst_req: grant inst.
  - Both requesting: grant data, unless starve_cnt >= STARVE_LIMIT, in which case grant inst.
- Grant in LOCK: grant is the registered sel.
- mem_wr, mem_size, mem_addr, mem_wdata, mem_uncached are muxed from the granted master.
- mem_req = granted master's req, in IDLE and LOCK only. mem_req = 0 in WAIT.
- Addr handshake: granted master's addr_ok = mem_addr_ok & mem_req. The other master's addr_ok = 0.
- Transitions:
  - IDLE, mem_req & mem_addr_ok: owner <= grant, go WAIT.
  - IDLE, mem_req & !mem_addr_ok: sel <= grant, go LOCK. The grant is frozen until accepted.
  - LOCK, granted req & mem_addr_ok: owner <= sel, go WAIT.
  - LOCK, granted req drops (e.g. ifetch exception): go IDLE. No transaction is issued and the counter is unchanged.
  - WAIT, mem_data_ok: go IDLE. The next request can be accepted no earlier than the following cycle.
- Data return: in WAIT, owner's data_ok = mem_data_ok. Both rdata outputs = mem_rdata at all times; consumers qualify with data_ok. The non-owner's data_ok = 0. data_ok is 0 in IDLE and LOCK.
- The slave never asserts mem_data_ok in the same cycle as mem_addr_ok. mem_data_ok outside WAIT is ignored.
- Starvation counter, updated on each address acceptance:
  - Data accepted while inst_req = 1: starve_cnt += 1, saturating at 15.
  - Inst accepted: starve_cnt <= 0.
  - Data accepted with inst_req = 0: starve_cnt unchanged.
- Latency: zero added cycles on the address path (combinational pass-through); data_ok is passed through combinationally.
- Reset mid-transaction: return to IDLE immediately. A late mem_data_ok after reset is dropped.

Test Plan:
- Lone fetch: inst_req = 1, inst_addr = 0xBFC00000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata 0x3C080000.
  -> mem_addr = 0xBFC00000; inst_addr_ok pulses once; inst_data_ok = 1 with inst_rdata = 0x3C080000; data_* acks stay 0.
- Simultaneous requests: inst @0x1000 and data write @0x2000, wdata 0xDEADBEEF, slave accepts immediately.
  -> data granted first (mem_wr = 1, mem_addr = 0x2000); inst granted on the cycle after the data transaction's data_ok.
- Starvation: inst_req held high, data_req continuously high, STARVE_LIMIT = 4.
  -> exactly 4 data transactions, then one inst transaction, then starve_cnt = 0.
- Lock and withdraw: inst granted, mem_addr_ok = 0 for 3 cycles.
  -> mem_addr stays the inst address while data_req rises. If inst_req drops in cycle 2, then IDLE, and data is granted the next cycle.
- Stray data_ok: mem_data_ok asserted while in IDLE -> both *_data_ok = 0, state unchanged.
- Reset in WAIT: rst for 1 cycle -> state = IDLE, starve_cnt = 0; a following mem_data_ok produces no data_ok.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master (ifetch, data) to one-slave sram-like bus arbiter.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_LIMIT.
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_uncached,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_uncached,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncached,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLock = 2'd1,
    StWait = 2'd2
  } state_e;

  state_e      r_state;
  logic        r_sel;
  logic        r_owner;
  logic [3:0]  r_starve_cnt;

  logic w_starved;
  logic w_grant;
  logic w_grant_req;
  logic w_accept;
  logic w_data_ok;

  always_comb begin
    w_starved = 32'(r_starve_cnt) >= STARVE_LIMIT;
    w_grant   = 1'b0;
    unique case (r_state)
      StIdle:  w_grant = data_req & ~(inst_req & w_starved);
      StLock:  w_grant = r_sel;
      default: w_grant = r_owner;
    endcase
    w_grant_req = w_grant ? data_req : inst_req;

    mem_req      = ~rst & (r_state != StWait) & w_grant_req;
    mem_wr       = w_grant ? data_wr       : inst_wr;
    mem_size     = w_grant ? data_size     : inst_size;
    mem_addr     = w_grant ? data_addr     : inst_addr;
    mem_wdata    = w_grant ? data_wdata    : inst_wdata;
    mem_uncached = w_grant ? data_uncached : inst_uncached;

    w_accept     = mem_req & mem_addr_ok;
    inst_addr_ok = w_accept & ~w_grant;
    data_addr_ok = w_accept & w_grant;

    // Stray mem_data_ok outside WAIT (or during reset) never reaches a master.
    w_data_ok    = ~rst & (r_state == StWait) & mem_data_ok;
    inst_data_ok = w_data_ok & ~r_owner;
    data_data_ok = w_data_ok & r_owner;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_sel        <= 1'b0;
      r_owner      <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (mem_req) begin
            if (mem_addr_ok) begin
              r_owner <= w_grant;
              r_state <= StWait;
            end else begin
              r_sel   <= w_grant;
              r_state <= StLock;
            end
          end
        end
        StLock: begin
          // A withdrawn request abandons the lock without issuing anything.
          if (!w_grant_req) begin
            r_state <= StIdle;
          end else if (mem_addr_ok) begin
            r_owner <= r_sel;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (mem_data_ok) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_accept) begin
        if (w_grant) begin
          if (inst_req && r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
          r_starve_cnt <= 4'd0;
        end
      end
    end
  end

endmodule
